instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory fetch interface: owns the fetch PC, drives the address into instruction_memory, and captures the returned word.
- instruction_memory answers combinationally.
- Fetched {pc, instruction, fault} entries are buffered in a 2-entry FIFO and presented to decode through a valid/ready handshake.
- Handles branch/jump redirects with flush, decode backpressure, and halting on an illegal fetch address.

Parameters:
RESET_PC, 32'h00000000, fetch address loaded on reset
NOP_INSTR, 32'h00000013, instruction presented when the buffer is empty or the entry is faulted
IMEM_WORDS, 1024, number of valid 32-bit words in instruction memory; word index >= IMEM_WORDS is illegal

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
imem_pc  output  32  fetch address to instruction_memory; equals fetch_pc combinationally
imem_instr  input  32  instruction returned combinationally for imem_pc
redirect_valid  input  1  redirect request from execute (branch taken / jump)
redirect_pc  input  32  redirect target address
out_valid  output  1  head entry valid
out_ready  input  1  decode accepts head entry
out_pc  output  32  PC of head entry
out_instr  output  32  instruction of head entry
out_fault  output  1  head entry is an illegal-address fetch

Behaviour:
- State: fetch_pc[31:0], FIFO (2 entries, 2-bit count, read/write pointers), FSM {RUN, HALT}.
- Reset (reset==0, async) takes effect immediately:
  - fetch_pc=RESET_PC, count=0, FSM=RUN.
  - out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_fault=0.
- Outputs:
  - out_valid = (count != 0).
  - When count==0: out_pc=0, out_instr=NOP_INSTR, out_fault=0.
  - Otherwise outputs show the head entry.
- pop = out_valid & out_ready.
- Illegal fetch address: fetch_pc[1:0] != 0, or fetch_pc[31:2] >= IMEM_WORDS.
- push = (FSM==RUN) & (count<2 | pop) & ~redirect_valid.
- On push:
  - Entry written is {fetch_pc, illegal ? NOP_INSTR : imem_instr, illegal}.
  - If illegal, FSM goes to HALT and fetch_pc holds.
  - Otherwise fetch_pc <= fetch_pc + 4, modulo 2^32.
- HALT: no pushes; fetch_pc holds; the buffered entries still drain through out_*.
- Redirect priority. When redirect_valid==1:
  - FIFO is flushed (count=0, pointers cleared); a same-cycle pop is discarded.
  - fetch_pc <= redirect_pc and FSM <= RUN.
  - Nothing is pushed that cycle; out_valid=0 on the next cycle.
  - The redirect target is fetched on the following edge.
- Simultaneous push and pop with count==2: legal; count stays 2 and order is preserved.
- Simultaneous push and pop with count==1: count stays 1; the new entry becomes head after the edge.
- Latency:
  - After reset release, the first edge pushes the RESET_PC entry; out_valid=1 from the next cycle.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
  - Redirect-to-valid latency is 2 edges.
- Backpressure: out_ready=0 with count==2 stalls fetch; fetch_pc and the FIFO contents are held exactly.
- Head-entry outputs must stay stable while out_valid=1 and out_ready=0.
- imem_pc is driven even in HALT (fetch_pc held); imem_instr is ignored unless a push occurs.

Test Plan:
1. Reset, then release with memory words 0..3 = A, B, C, D and out_ready=1 → out_pc sequence 0, 4, 8, C with out_instr A, B, C, D on consecutive cycles; out_valid first high one cycle after the first edge.
2. Drop out_ready after pc=0 is fetched → count reaches 2 (entries pc 0 and pc 4); imem_pc holds 8; outputs stay pc 0/A. Raise out_ready → 0, 4, 8 are delivered with no gap or duplicate.
3. Redirect to 0x40 while count==2 and out_ready=1 → the next cycle has out_valid=0; the cycle after shows out_pc=0x40 with imem[16]; stale entries are never presented.
4. Redirect to 0x42 → one entry out_pc=0x42, out_instr=0x00000013, out_fault=1; then out_valid=0 indefinitely; a redirect to 0x0 resumes normal fetch.
5. Redirect to 0xFFC → entry 0xFFC is valid with no fault, then entry 0x1000 has out_fault=1, then HALT with imem_pc held at 0x1000.
6. Assert reset mid-stream while count==2 → immediately out_valid=0 and out_instr=0x00000013, without waiting for an edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, execute redirect and decode handshake.
interface instruction_fetch_unit_if;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  modport master (
    output imem_pc,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output out_fault
  );

  modport slave (
    input  imem_pc,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  out_fault
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the fetch PC, reads a combinational instruction memory and
// buffers {pc, instr, fault} in a 2-entry FIFO towards decode; halts on an illegal address.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } entry_t;

  typedef enum logic {RUN, HALT} state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  entry_t           fifo_q [DEPTH];
  entry_t           head;
  entry_t           wr_entry;
  logic             illegal;
  logic             push;
  logic             pop;

  // Misaligned or beyond the end of instruction memory.
  assign illegal = (pc_q[1:0] != 2'b00) ||
                   ({2'b00, pc_q[XLEN-1:2]} >= 32'(IMEM_WORDS));

  // Next-state: redirect flushes and wins over any push/pop in the same cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    push     = 1'b0;
    pop      = (count_q != '0) && bus.out_ready;
    wr_entry = '{pc: pc_q, instr: (illegal ? NOP_INSTR : bus.imem_instr), fault: illegal};

    if (bus.redirect_valid) begin
      count_d = '0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      pc_d    = bus.redirect_pc;
      state_d = RUN;
    end else begin
      push = (state_q == RUN) && ((count_q < CNT_W'(DEPTH)) || pop);
      if (push) begin
        wr_d = ~wr_q;
        if (illegal) begin
          state_d = HALT;
        end else begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      if (pop) begin
        rd_d = ~rd_q;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // PC and FIFO storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      fifo_q  <= '{default: '0};
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      if (push) begin
        fifo_q[wr_q] <= wr_entry;
      end
    end
  end

  assign head          = fifo_q[rd_q];
  assign bus.imem_pc   = pc_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_pc    = bus.out_valid ? head.pc    : '0;
  assign bus.out_instr = bus.out_valid ? head.instr : NOP_INSTR;
  assign bus.out_fault = bus.out_valid ? head.fault : 1'b0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a reference fetch model queues expected
// entries as they are fetched and retires them as decode accepts them.
module tb_instruction_fetch_unit;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned WORDS = 1024;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem [WORDS];

  logic [31:0] m_pc;
  bit          m_halt;
  exp_t        sb [$];
  int          n_pass   = 0;
  int          n_checks = 0;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP),
    .IMEM_WORDS(WORDS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory; out-of-range reads return junk the DUT must ignore.
  always_comb begin
    if (bus.imem_pc[31:12] == 20'h0) bus.imem_instr = mem[bus.imem_pc[11:2]];
    else                              bus.imem_instr = 32'hBAD0_BAD0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit is_illegal(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc[31:2] >= 30'(WORDS));
  endfunction

  task automatic model_reset();
    m_pc   = 32'h0;
    m_halt = 1'b0;
    sb.delete();
  endtask

  task automatic check_outputs(input string tag);
    exp_t h;
    if (sb.size() != 0) h = sb[0];
    else                h = '{pc: 32'h0, instr: NOP, fault: 1'b0};
    check_eq({tag, ":imem_pc"}, bus.imem_pc, m_pc);
    check_eq({tag, ":valid"}, 32'(bus.out_valid), 32'(sb.size() != 0));
    check_eq({tag, ":pc"}, bus.out_pc, h.pc);
    check_eq({tag, ":instr"}, bus.out_instr, h.instr);
    check_eq({tag, ":fault"}, 32'(bus.out_fault), 32'(h.fault));
  endtask

  // Advance the model with the currently driven inputs, clock once, then compare.
  task automatic step(input string tag);
    int sz;
    bit pop;
    bit push;
    bit ill;
    sz   = sb.size();
    pop  = (sz != 0) && bus.out_ready;
    push = 1'b0;
    if (bus.redirect_valid) begin
      sb.delete();
      m_pc   = bus.redirect_pc;
      m_halt = 1'b0;
    end else begin
      push = !m_halt && ((sz < 2) || pop);
      if (pop) void'(sb.pop_front());
      if (push) begin
        ill = is_illegal(m_pc);
        sb.push_back('{pc: m_pc, instr: (ill ? NOP : mem[m_pc[11:2]]), fault: ill});
        if (ill) m_halt = 1'b1;
        else     m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic redirect_to(input logic [31:0] target, input string tag);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    step(tag);
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(WORDS); i++) mem[i] = 32'(i) * 32'h9E37_79B1 + 32'h0000_1357;

    reset              = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    model_reset();
    #2;
    check_outputs("reset");
    check_eq("reset_instr_nop", bus.out_instr, NOP);
    @(posedge clk);
    #1;
    check_outputs("reset_hold");

    // 1: straight-line fetch after reset release.
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    step("t1_first");
    check_eq("t1_first_valid", 32'(bus.out_valid), 32'd1);
    check_eq("t1_first_pc", bus.out_pc, 32'h0);
    check_eq("t1_first_instr", bus.out_instr, mem[0]);
    for (int k = 1; k < 4; k++) begin
      step("t1_seq");
      check_eq("t1_seq_pc", bus.out_pc, 32'(k) * 32'd4);
      check_eq("t1_seq_instr", bus.out_instr, mem[k]);
    end

    // 2: backpressure fills the FIFO and holds fetch.
    redirect_to(32'h0, "t2_redir");
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) step("t2_stall");
    check_eq("t2_imem_hold", bus.imem_pc, 32'h8);
    check_eq("t2_head_pc", bus.out_pc, 32'h0);
    check_eq("t2_head_instr", bus.out_instr, mem[0]);
    bus.out_ready = 1'b1;
    step("t2_drain");
    check_eq("t2_drain_pc4", bus.out_pc, 32'h4);
    step("t2_drain");
    check_eq("t2_drain_pc8", bus.out_pc, 32'h8);

    // 3: redirect with a full FIFO discards stale entries.
    redirect_to(32'h40, "t3_redir");
    check_eq("t3_bubble", 32'(bus.out_valid), 32'd0);
    step("t3_target");
    check_eq("t3_target_pc", bus.out_pc, 32'h40);
    check_eq("t3_target_instr", bus.out_instr, mem[16]);
    for (int k = 0; k < 3; k++) step("t3_run");

    // 4: misaligned redirect faults then halts until redirected again.
    redirect_to(32'h42, "t4_redir");
    step("t4_fault");
    check_eq("t4_fault_pc", bus.out_pc, 32'h42);
    check_eq("t4_fault_instr", bus.out_instr, NOP);
    check_eq("t4_fault_flag", 32'(bus.out_fault), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step("t4_halt");
      check_eq("t4_halt_valid", 32'(bus.out_valid), 32'd0);
      check_eq("t4_halt_imem", bus.imem_pc, 32'h42);
    end
    redirect_to(32'h0, "t4_resume_redir");
    for (int k = 0; k < 3; k++) step("t4_resume");

    // 5: running off the end of memory.
    redirect_to(32'hFFC, "t5_redir");
    step("t5_last");
    check_eq("t5_last_pc", bus.out_pc, 32'hFFC);
    check_eq("t5_last_fault", 32'(bus.out_fault), 32'd0);
    check_eq("t5_last_instr", bus.out_instr, mem[1023]);
    step("t5_oob");
    check_eq("t5_oob_pc", bus.out_pc, 32'h1000);
    check_eq("t5_oob_fault", 32'(bus.out_fault), 32'd1);
    for (int k = 0; k < 3; k++) step("t5_halt");
    check_eq("t5_halt_imem", bus.imem_pc, 32'h1000);

    // Random backpressure and redirects against the model.
    redirect_to(32'h0, "rnd_start");
    for (int n = 0; n < 400; n++) begin
      int r;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        r = int'($urandom_range(0, 9));
        bus.redirect_valid = 1'b1;
        if (r < 7)       bus.redirect_pc = 32'($urandom_range(0, 1023)) << 2;
        else if (r == 7) bus.redirect_pc = 32'hFF0 + (32'($urandom_range(0, 3)) << 2);
        else if (r == 8) bus.redirect_pc = $urandom;
        else             bus.redirect_pc = (32'($urandom_range(0, 1023)) << 2) + 32'd2;
      end else begin
        bus.redirect_valid = 1'b0;
      end
      step("rnd");
    end
    bus.redirect_valid = 1'b0;

    // 6: asynchronous reset with a full FIFO.
    redirect_to(32'h100, "t6_redir");
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) step("t6_fill");
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_async_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t6_async_instr", bus.out_instr, NOP);
    check_eq("t6_async_imem", bus.imem_pc, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("t6_in_reset");
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    step("t6_restart");
    check_eq("t6_restart_pc", bus.out_pc, 32'h0);
    check_eq("t6_restart_instr", bus.out_instr, mem[0]);
    for (int k = 0; k < 4; k++) step("t6_run");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
